wb_commit_trace: RTL and testbench

- Consumer at the far end of the WB pipeline register. Takes each committed WB-stage instruction, resolves the final register write data from the WbSel select, and queues it as a commit-trace record.
- Drains records through a valid/ready interface to the debug/difftest port.
- Asserts a stall request toward the pipeline hazard unit before the queue can overflow.

---
 rtl/wb_commit_trace_pkg.sv | 36 +++
 rtl/wb_commit_trace_fifo.sv | 63 ++++++
 rtl/wb_commit_trace.sv | 87 ++++++++
 tb/tb_wb_commit_trace.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_commit_trace_pkg.sv
// Shared definitions for the WB commit-trace block: write-back select codes,
// the trace record layout, and the write-back data mux.
package wb_commit_trace_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_DM   = 2'b01;
  localparam logic [1:0] WB_SEL_PC8  = 2'b10;
  localparam logic [1:0] WB_SEL_OUTB = 2'b11;

  // 105-bit record, pc in the MSBs.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [3:0]  rf_wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } TraceRecType;

  function automatic logic [31:0] wb_sel_data(
    input logic [1:0]  sel,
    input logic [31:0] alu_out,
    input logic [31:0] dm_out,
    input logic [31:0] pc,
    input logic [31:0] out_b
  );
    logic [31:0] res;
    case (sel)
      WB_SEL_ALU:  res = alu_out;
      WB_SEL_DM:   res = dm_out;
      WB_SEL_PC8:  res = pc + 32'd8;
      default:     res = out_b;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wb_commit_trace_fifo.sv
// Synchronous circular-buffer FIFO of trace records. A push while full is only
// taken when a pop frees the head slot in the same cycle.
module wb_commit_trace_fifo
  import wb_commit_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  TraceRecType              din_i,
  output TraceRecType              dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  TraceRecType     mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [PW:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_FULL);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
    end
  end

  // Storage carries data only; reset just discards it via the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/wb_commit_trace.sv
// Commit-trace capture at the end of WB: builds a record per committed
// instruction, queues it, and back-pressures the pipeline before overflow.
module wb_commit_trace
  import wb_commit_trace_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter bit PUSH_ALL = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_commit,
  input  logic [31:0]            wb_pc,
  input  logic [31:0]            wb_instr,
  input  logic [1:0]             wb_wbsel,
  input  logic [31:0]            wb_alu_out,
  input  logic [31:0]            wb_dm_out,
  input  logic [31:0]            wb_out_b,
  input  logic [4:0]             wb_dst,
  input  logic                   wb_rf_wr,
  input  logic                   trace_ready,
  output logic                   trace_valid,
  output logic [31:0]            trace_pc,
  output logic [31:0]            trace_instr,
  output logic [3:0]             trace_rf_wen,
  output logic [4:0]             trace_wnum,
  output logic [31:0]            trace_wdata,
  output logic                   stall_req,
  output logic [$clog2(DEPTH):0] trace_count,
  output logic                   overflow
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_STALL = CW'(DEPTH - 1);

  TraceRecType   rec_in, head;
  logic [3:0]    rf_wen;
  logic          writes_rf;
  logic          push, pop, full, empty;
  logic [CW-1:0] count;
  logic          overflow_q, overflow_d;

  assign writes_rf = wb_rf_wr && (wb_dst != 5'd0);
  assign rf_wen    = writes_rf ? 4'hF : 4'h0;

  always_comb begin
    rec_in        = '0;
    rec_in.pc     = wb_pc;
    rec_in.instr  = wb_instr;
    rec_in.rf_wen = rf_wen;
    rec_in.wnum   = writes_rf ? wb_dst : 5'd0;
    rec_in.wdata  = wb_sel_data(wb_wbsel, wb_alu_out, wb_dm_out, wb_pc, wb_out_b);
  end

  assign push = wb_commit && (PUSH_ALL || writes_rf);
  assign pop  = trace_valid && trace_ready;

  wb_commit_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (rec_in),
    .dout_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // A record is lost only when full with no pop to make room.
  assign overflow_d = overflow_q || (push && full && !pop);

  always_ff @(posedge clk) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_d;
  end

  assign trace_valid  = !empty;
  assign trace_pc     = head.pc;
  assign trace_instr  = head.instr;
  assign trace_rf_wen = head.rf_wen;
  assign trace_wnum   = head.wnum;
  assign trace_wdata  = head.wdata;
  assign trace_count  = count;
  assign stall_req    = (count >= CNT_STALL);
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_wb_commit_trace.sv
// Bench for wb_commit_trace: two instances (PUSH_ALL=0 and 1) share stimulus
// and are checked every cycle against a queue-based reference model.
module tb_wb_commit_trace;

  localparam int DEPTH = 8;
  localparam int CW    = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } rec_t;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] pc, alu, dm, outb;
    logic [4:0]  dst;
    logic        wr;
    logic        v0;
    logic [31:0] wd;
    logic [3:0]  wen1;
    logic [4:0]  wnum1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_commit, wb_rf_wr, trace_ready;
  logic [31:0] wb_pc, wb_instr, wb_alu_out, wb_dm_out, wb_out_b;
  logic [1:0]  wb_wbsel;
  logic [4:0]  wb_dst;

  logic          t_valid [2];
  logic [31:0]   t_pc    [2];
  logic [31:0]   t_instr [2];
  logic [3:0]    t_wen   [2];
  logic [4:0]    t_wnum  [2];
  logic [31:0]   t_wdata [2];
  logic          t_stall [2];
  logic [CW-1:0] t_count [2];
  logic          t_ovf   [2];

  rec_t       mq0[$];
  rec_t       mq1[$];
  logic [1:0] movf;
  int         passed = 0;
  int         total  = 0;
  vec_t       vecs[6];

  always #5 clk = ~clk;

  wb_commit_trace #(.DEPTH(DEPTH), .PUSH_ALL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .wb_commit(wb_commit), .wb_pc(wb_pc), .wb_instr(wb_instr),
    .wb_wbsel(wb_wbsel), .wb_alu_out(wb_alu_out), .wb_dm_out(wb_dm_out),
    .wb_out_b(wb_out_b), .wb_dst(wb_dst), .wb_rf_wr(wb_rf_wr), .trace_ready(trace_ready),
    .trace_valid(t_valid[0]), .trace_pc(t_pc[0]), .trace_instr(t_instr[0]),
    .trace_rf_wen(t_wen[0]), .trace_wnum(t_wnum[0]), .trace_wdata(t_wdata[0]),
    .stall_req(t_stall[0]), .trace_count(t_count[0]), .overflow(t_ovf[0])
  );

  wb_commit_trace #(.DEPTH(DEPTH), .PUSH_ALL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .wb_commit(wb_commit), .wb_pc(wb_pc), .wb_instr(wb_instr),
    .wb_wbsel(wb_wbsel), .wb_alu_out(wb_alu_out), .wb_dm_out(wb_dm_out),
    .wb_out_b(wb_out_b), .wb_dst(wb_dst), .wb_rf_wr(wb_rf_wr), .trace_ready(trace_ready),
    .trace_valid(t_valid[1]), .trace_pc(t_pc[1]), .trace_instr(t_instr[1]),
    .trace_rf_wen(t_wen[1]), .trace_wnum(t_wnum[1]), .trace_wdata(t_wdata[1]),
    .stall_req(t_stall[1]), .trace_count(t_count[1]), .overflow(t_ovf[1])
  );

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s dut%0d: got %h expected %h", nm, k, act, exp);
  endtask

  function automatic rec_t mk_rec();
    rec_t r;
    logic w;
    w = wb_rf_wr && (wb_dst != 0);
    r.pc    = wb_pc;
    r.instr = wb_instr;
    r.wen   = w ? 4'hF : 4'h0;
    r.wnum  = w ? wb_dst : 5'd0;
    case (wb_wbsel)
      2'b00:   r.wdata = wb_alu_out;
      2'b01:   r.wdata = wb_dm_out;
      2'b10:   r.wdata = wb_pc + 32'd8;
      default: r.wdata = wb_out_b;
    endcase
    return r;
  endfunction

  // Reference: queue semantics straight from the acceptance rules.
  task automatic model_edge();
    rec_t r;
    bit   push0, push1, pop0, pop1, full0, full1;
    if (rst) begin
      mq0.delete();
      mq1.delete();
      movf = 2'b00;
      return;
    end
    r     = mk_rec();
    pop0  = (mq0.size() != 0) && trace_ready;
    pop1  = (mq1.size() != 0) && trace_ready;
    push0 = wb_commit && (r.wen != 0);
    push1 = wb_commit;
    full0 = (mq0.size() == DEPTH);
    full1 = (mq1.size() == DEPTH);
    if (pop0) void'(mq0.pop_front());
    if (pop1) void'(mq1.pop_front());
    if (push0) begin
      if (!full0 || pop0) mq0.push_back(r);
      else movf[0] = 1'b1;
    end
    if (push1) begin
      if (!full1 || pop1) mq1.push_back(r);
      else movf[1] = 1'b1;
    end
  endtask

  task automatic check_all();
    rec_t h;
    int   n;
    for (int k = 0; k < 2; k++) begin
      n = (k == 0) ? mq0.size() : mq1.size();
      h = '0;
      if (n != 0) h = (k == 0) ? mq0[0] : mq1[0];
      chk("valid", k, 32'(t_valid[k]), 32'(n != 0));
      chk("pc",    k, t_pc[k], h.pc);
      chk("instr", k, t_instr[k], h.instr);
      chk("rf_wen",k, 32'(t_wen[k]), 32'(h.wen));
      chk("wnum",  k, 32'(t_wnum[k]), 32'(h.wnum));
      chk("wdata", k, t_wdata[k], h.wdata);
      chk("count", k, 32'(t_count[k]), 32'(n));
      chk("stall", k, 32'(t_stall[k]), 32'(n >= DEPTH - 1));
      chk("ovf",   k, 32'(t_ovf[k]), 32'(movf[k]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wb_commit = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic set_writer(input logic [31:0] data, input logic [4:0] dst);
    wb_commit  = 1'b1;
    wb_wbsel   = 2'b00;
    wb_alu_out = data;
    wb_pc      = data << 2;
    wb_instr   = ~data;
    wb_dst     = dst;
    wb_rf_wr   = 1'b1;
  endtask

  initial begin
    vecs[0] = '{2'b00, 32'hBFC00000, 32'h1234, 32'h0, 32'h0, 5'd5, 1'b1, 1'b1, 32'h1234, 4'hF, 5'd5};
    vecs[1] = '{2'b10, 32'hFFFFFFFC, 32'h1, 32'h2, 32'h3, 5'd31, 1'b1, 1'b1, 32'h00000004, 4'hF, 5'd31};
    vecs[2] = '{2'b01, 32'h00400010, 32'h1, 32'hDEADBEEF, 32'h3, 5'd2, 1'b1, 1'b1, 32'hDEADBEEF, 4'hF, 5'd2};
    vecs[3] = '{2'b11, 32'h00400020, 32'h1, 32'h2, 32'hCAFEF00D, 5'd9, 1'b1, 1'b1, 32'hCAFEF00D, 4'hF, 5'd9};
    vecs[4] = '{2'b00, 32'h00400030, 32'h55, 32'h2, 32'h3, 5'd0, 1'b1, 1'b0, 32'h55, 4'h0, 5'd0};
    vecs[5] = '{2'b00, 32'h00400040, 32'h66, 32'h2, 32'h3, 5'd7, 1'b0, 1'b0, 32'h66, 4'h0, 5'd0};

    movf = 2'b00;
    rst = 1'b1; wb_commit = 1'b0; wb_rf_wr = 1'b0; trace_ready = 1'b0;
    wb_pc = '0; wb_instr = '0; wb_wbsel = '0; wb_alu_out = '0; wb_dm_out = '0;
    wb_out_b = '0; wb_dst = '0;
    @(negedge clk);
    do_reset();

    // Table-driven data-select and push-qualification vectors.
    trace_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wb_commit  = 1'b1;
      wb_wbsel   = vecs[i].sel;
      wb_pc      = vecs[i].pc;
      wb_instr   = 32'h1000_0000 + i;
      wb_alu_out = vecs[i].alu;
      wb_dm_out  = vecs[i].dm;
      wb_out_b   = vecs[i].outb;
      wb_dst     = vecs[i].dst;
      wb_rf_wr   = vecs[i].wr;
      step();
      chk("vec_valid0", i, 32'(t_valid[0]), 32'(vecs[i].v0));
      if (vecs[i].v0) chk("vec_wdata0", i, t_wdata[0], vecs[i].wd);
      chk("vec_valid1", i, 32'(t_valid[1]), 32'd1);
      chk("vec_wdata1", i, t_wdata[1], vecs[i].wd);
      chk("vec_wen1",   i, 32'(t_wen[1]), 32'(vecs[i].wen1));
      chk("vec_wnum1",  i, 32'(t_wnum[1]), 32'(vecs[i].wnum1));
      wb_commit = 1'b0;
      step();
      chk("vec_drained", i, 32'(t_count[0]) + 32'(t_count[1]), 32'd0);
    end

    // Fill to full, overflow on the 9th, then drain in order.
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_writer(32'd100 + i, 5'(i + 1));
      step();
      if (i == 5) chk("stall_at6", 0, 32'(t_stall[0]), 32'd0);
      if (i == 6) chk("stall_at7", 0, 32'(t_stall[0]), 32'd1);
      if (i == 7) chk("count_at8", 0, 32'(t_count[0]), 32'd8);
      if (i == 8) chk("ovf_9th", 0, 32'(t_ovf[0]), 32'd1);
    end
    wb_commit = 1'b0;
    trace_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_order", i, t_wdata[0], 32'd100 + i);
      step();
    end
    chk("drained_empty", 0, 32'(t_valid[0]), 32'd0);

    // Full queue with simultaneous push and pop.
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_writer(32'd300 + i, 5'd3);
      step();
    end
    trace_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("pp_head", i, t_wdata[0], (i < 8) ? 32'd300 + i : 32'd200 + (i - 8));
      set_writer(32'd200 + i, 5'd4);
      step();
      chk("pp_count", i, 32'(t_count[0]), 32'd8);
    end
    chk("pp_no_ovf", 0, 32'(t_ovf[0]), 32'd0);

    // Reset mid-operation with 5 queued and overflow set.
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_writer(32'd500 + i, 5'd6);
      step();
    end
    wb_commit = 1'b0;
    trace_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("pre_rst_count", 0, 32'(t_count[0]), 32'd5);
    chk("pre_rst_ovf", 0, 32'(t_ovf[0]), 32'd1);
    trace_ready = 1'b0;
    do_reset();
    chk("rst_count", 0, 32'(t_count[0]), 32'd0);
    chk("rst_valid", 0, 32'(t_valid[0]), 32'd0);
    chk("rst_ovf",   0, 32'(t_ovf[0]), 32'd0);
    chk("rst_stall", 0, 32'(t_stall[0]), 32'd0);

    // Randomized traffic with varying back-pressure.
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 150) == 0);
      wb_commit   = ($urandom_range(0, 3) != 0);
      trace_ready = ((i / 60) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      wb_wbsel    = 2'($urandom_range(0, 3));
      wb_pc       = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7)) : $urandom;
      wb_instr    = $urandom;
      wb_alu_out  = $urandom;
      wb_dm_out   = $urandom;
      wb_out_b    = $urandom;
      wb_dst      = 5'($urandom_range(0, 7));
      wb_rf_wr    = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
